// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state type and default parameters for the UART receive path
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF = 5;
endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: frame delivery bus between the receiver (master) and its consumer (slave)
// rx_data/rx_valid/frame_err/overrun/busy driven by the receiver, rx_ready by the consumer
// parity_err exists only when UART_RX_PARITY_EN is defined
interface uart_rx_deserializer_if #(parameter int DATA_W = uart_rx_pkg::DATA_W_DEF);
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic frame_err;
  logic overrun;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  modport master(output rx_data, rx_valid, frame_err, overrun, busy, parity_err, input rx_ready);
  modport slave(input rx_data, rx_valid, frame_err, overrun, busy, parity_err, output rx_ready);
`else
  modport master(output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave(input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
`endif
endinterface

// File: rtl/uart_rx_deserializer_rx_bit_timer.sv
// rx_bit_timer: free-running bit timer that ticks and wraps when the count reaches max
// clk, nrst: clock and async active-low reset
// clear: force count to 0; count_enable: advance count; max: terminal count; tick: count == max while enabled
module rx_bit_timer #(
  parameter int CNT_W = uart_rx_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] max,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  assign tick = count_enable && !clear && cnt == max;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) cnt <= '0;
    else cnt <= clear || tick ? '0 : count_enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receiver, mid-bit sampling, LSB-first shift, stop check, valid/ready delivery
// clk, nrst: clock and async active-low reset; rx_serial: idle-high serial line (asynchronous)
// bus (master): rx_data/rx_valid held until rx_ready, frame_err/overrun pulses, busy while not IDLE
// UART_RX_PARITY_EN: adds an even-parity bit after the data bits and the parity_err pulse
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic nrst,
  input logic rx_serial,
  uart_rx_deserializer_if.master bus
);
  localparam int BC_W = $clog2(DATA_W + 1);
  logic s1, s2;
  rx_state_t state, nxt;
  logic [CNT_W-1:0] tmax;
  logic tick, last, stop_tick, good, pok, hold;
  logic [BC_W-1:0] bcnt;
  logic [DATA_W-1:0] sh;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  logic par;
  assign pok = ~^{sh, par};
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) par <= 1'b0;
    else if (state == PARITY && tick) par <= s2;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) bus.parity_err <= 1'b0;
    else bus.parity_err <= stop_tick && s2 && !pok;
`else
  localparam rx_state_t AFTER_DATA = STOP;
  assign pok = 1'b1;
`endif
  rx_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .nrst(nrst),
    .clear(state == IDLE),
    .count_enable(state != IDLE),
    .max(tmax),
    .tick(tick)
  );
  // START waits half a bit so every later full-bit tick lands mid-bit
  assign tmax = state == START ? CNT_W'(CLKS_PER_BIT / 2 - 1) : CNT_W'(CLKS_PER_BIT - 1);
  assign last = bcnt == BC_W'(DATA_W - 1);
  assign stop_tick = state == STOP && tick;
  assign good = stop_tick && s2 && pok;
  assign hold = bus.rx_valid && !bus.rx_ready;
  assign bus.busy = state != IDLE;
  always_comb
    nxt = state == IDLE ? (s2 ? IDLE : START) :
          state == START ? (tick ? (s2 ? IDLE : DATA) : START) :
          state == DATA ? (tick && last ? AFTER_DATA : DATA) :
          state == PARITY ? (tick ? STOP : PARITY) :
          tick ? IDLE : STOP;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= IDLE;
      bcnt <= '0;
      sh <= '0;
    end else begin
      s1 <= rx_serial;
      s2 <= s1;
      state <= nxt;
      bcnt <= state == IDLE ? '0 : state == DATA && tick ? bcnt + 1'b1 : bcnt;
      if (state == DATA && tick) sh <= {s2, sh[DATA_W-1:1]};
    end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.frame_err <= stop_tick && !s2;
      bus.overrun <= good && hold;
      bus.rx_valid <= good || hold;
      if (good && !hold) bus.rx_data <= sh;
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames with a scoreboard of expected deliveries and flag pulses
module tb_uart_rx_deserializer;
  localparam int CPB = 16;
  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int STOP_EDGE = 3 + CPB / 2 + CPB * (NB + 1);
  localparam int K_DATA = 0, K_FERR = 1, K_OVR = 2, K_PERR = 3;
  typedef struct {int kind; logic [7:0] data;} ev_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic rx_serial = 1'b1;
  ev_t q[$];
  int cmp = 0;
  int err = 0;
  uart_rx_deserializer_if #(.DATA_W(DW)) bus();
  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .CNT_W(5)) dut (
    .clk(clk),
    .nrst(nrst),
    .rx_serial(rx_serial),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [NB-1:0] fr(input logic [DW-1:0] d);
`ifdef UART_RX_PARITY_EN
    fr = {^d, d};
`else
    fr = d;
`endif
  endfunction
  task automatic push(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    q.push_back(e);
  endtask
  task automatic expect_ev(input int k, input logic [7:0] d, input string nm);
    int idx = -1;
    for (int i = 0; i < q.size(); i++) if (idx < 0 && q[i].kind == k) idx = i;
    cmp++;
    if (idx < 0) begin
      err++;
      $display("FAIL %s: unexpected event (data %h), required none", nm, d);
    end else begin
      if (k == K_DATA && q[idx].data !== d) begin
        err++;
        $display("FAIL %s: got %h, required %h", nm, d, q[idx].data);
      end
      q.delete(idx);
    end
  endtask
  always @(negedge clk)
    if (nrst) begin
      if (bus.rx_valid && bus.rx_ready) expect_ev(K_DATA, bus.rx_data, "rx_data");
      if (bus.frame_err) expect_ev(K_FERR, 8'h00, "frame_err");
      if (bus.overrun) expect_ev(K_OVR, 8'h00, "overrun");
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err) expect_ev(K_PERR, 8'h00, "parity_err");
`endif
    end
  task automatic chk1(input string nm, input logic a, input logic e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %b, required %b", nm, a, e);
    end
  endtask
  task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h, required %h", nm, a, e);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [NB-1:0] bits, input logic stop);
    @(posedge clk);
    #1 rx_serial = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < NB; i++) begin
      #1 rx_serial = bits[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_serial = stop;
    repeat (CPB) @(posedge clk);
    #1 rx_serial = 1'b1;
  endtask
  task automatic chk_outs_zero(input string nm);
    chk1({nm, "_valid"}, bus.rx_valid, 1'b0);
    chk8({nm, "_data"}, bus.rx_data, 8'h00);
    chk1({nm, "_ferr"}, bus.frame_err, 1'b0);
    chk1({nm, "_ovr"}, bus.overrun, 1'b0);
    chk1({nm, "_busy"}, bus.busy, 1'b0);
  endtask
  initial begin
    bus.rx_ready = 1'b1;
    idle(3);
    chk_outs_zero("reset");
    nrst = 1'b1;
    idle(5);
    @(posedge clk);
    #1 rx_serial = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 rx_serial = 1'b1;
    repeat (CPB) @(posedge clk);
    #1 rx_serial = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 chk1("mid_busy", bus.busy, 1'b1);
    nrst = 1'b0;
    #1 chk_outs_zero("async_rst");
    rx_serial = 1'b1;
    idle(3);
    nrst = 1'b1;
    idle(5);
    chk1("post_rst_busy", bus.busy, 1'b0);
    push(K_DATA, 8'h3C);
    send_frame(fr(8'h3C), 1'b1);
    idle(20);
    push(K_DATA, 8'hA5);
    fork
      send_frame(fr(8'hA5), 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 chk1("a5_pre_valid", bus.rx_valid, 1'b0);
        @(posedge clk);
        #1 chk1("a5_valid", bus.rx_valid, 1'b1);
        chk8("a5_data", bus.rx_data, 8'hA5);
      end
    join
    idle(20);
    chk1("a5_valid_cleared", bus.rx_valid, 1'b0);
    @(posedge clk);
    #1 rx_serial = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_serial = 1'b1;
    idle(3);
    chk1("glitch_busy", bus.busy, 1'b1);
    idle(20);
    chk1("glitch_idle", bus.busy, 1'b0);
    chk1("glitch_valid", bus.rx_valid, 1'b0);
    push(K_FERR, 8'h00);
    send_frame(fr(8'h55), 1'b0);
    idle(40);
    chk1("ferr_valid", bus.rx_valid, 1'b0);
    chk1("ferr_idle", bus.busy, 1'b0);
    bus.rx_ready = 1'b0;
    push(K_DATA, 8'h11);
    send_frame(fr(8'h11), 1'b1);
    idle(20);
    chk1("ovr_hold_valid", bus.rx_valid, 1'b1);
    chk8("ovr_hold_data", bus.rx_data, 8'h11);
    push(K_OVR, 8'h00);
    send_frame(fr(8'h22), 1'b1);
    idle(20);
    chk1("ovr_kept_valid", bus.rx_valid, 1'b1);
    chk8("ovr_kept_data", bus.rx_data, 8'h11);
    bus.rx_ready = 1'b1;
    idle(1);
    chk1("ovr_drained", bus.rx_valid, 1'b0);
    bus.rx_ready = 1'b0;
    push(K_DATA, 8'h11);
    send_frame(fr(8'h11), 1'b1);
    idle(20);
    push(K_DATA, 8'h22);
    fork
      send_frame(fr(8'h22), 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
      end
    join
    idle(20);
    chk1("same_cycle_valid", bus.rx_valid, 1'b1);
    chk8("same_cycle_data", bus.rx_data, 8'h22);
    bus.rx_ready = 1'b1;
    idle(1);
    chk1("same_cycle_drained", bus.rx_valid, 1'b0);
`ifdef UART_RX_PARITY_EN
    push(K_DATA, 8'h07);
    send_frame({1'b1, 8'h07}, 1'b1);
    idle(20);
    push(K_PERR, 8'h00);
    send_frame({1'b0, 8'h07}, 1'b1);
    idle(20);
    chk1("perr_valid", bus.rx_valid, 1'b0);
    push(K_FERR, 8'h00);
    send_frame({1'b0, 8'h07}, 1'b0);
    idle(40);
    chk1("perr_ferr_valid", bus.rx_valid, 1'b0);
`endif
    idle(5);
    cmp++;
    if (q.size() != 0) begin
      err++;
      $display("FAIL queue_drain: %0d expected events never seen, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
